// File: rtl/jesd_link_sequencer.sv
// Bring-up and supervision FSM for the AD9081 JESD204C link: device reset, HMC sync, RX/TX enables, link watch with retry.
// Define JLS_SYSREF_GATE_EN to require SYSREF_MIN synced SYSREF rising edges before WAIT_LINK may enter RUN.
module jesd_link_sequencer #(
  parameter int         RST_CYCLES    = 1000,
  parameter int         SETTLE_CYCLES = 10000,
  parameter int         SYNC_CYCLES   = 16,
  parameter int         LINK_TIMEOUT  = 1000000,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [1:0] RXEN_MASK     = 2'b11,
  parameter logic [1:0] TXEN_MASK     = 2'b00,
  parameter int         CNT_W         = 24,
  parameter int         SYSREF_MIN    = 4,
  localparam int        RTY_W         = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             link_up_i,
  input  logic             sysref_i,
  output logic             rstb_o,
  output logic             hmc_sync_o,
  output logic [1:0]       rxen_o,
  output logic [1:0]       txen_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             lost,
  output logic [2:0]       state_o,
  output logic [RTY_W-1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SYNC      = 3'd3,
    ST_ENABLE    = 3'd4,
    ST_WAIT_LINK = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_load;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               link_meta, link_s;
  logic               gate_ok;

  // Two-flop synchronizer for the asynchronous link status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_meta <= 1'b0;
      link_s    <= 1'b0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      link_meta <= link_up_i;
      link_s    <= link_meta;
    end
  end

`ifdef JLS_SYSREF_GATE_EN
  localparam int EDGE_W = (SYSREF_MIN < 1) ? 1 : $clog2(SYSREF_MIN + 1);

  // [0],[1] synchronize; [2] holds the previous synced value for edge detection.
  logic [2:0]        sysref_sr;
  logic [EDGE_W-1:0] edge_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sysref_sr  <= '0;
      edge_cnt_q <= '0;
    end else begin
      sysref_sr <= {sysref_sr[1:0], sysref_i};
      if (state_q == ST_ENABLE)
        edge_cnt_q <= '0;
      else if (sysref_sr[1] && !sysref_sr[2] && (edge_cnt_q < EDGE_W'(SYSREF_MIN)))
        edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
    end
  end

  assign gate_ok = (edge_cnt_q >= EDGE_W'(SYSREF_MIN));
`else
  logic sysref_unused;
  assign sysref_unused = sysref_i;
  assign gate_ok       = 1'b1;
`endif

  // Timer is reloaded with (duration - 1) whenever the state changes, so a state lasts exactly its duration.
  always_comb begin
    timer_load = '0;
    case (state_d)
      ST_RESET:     timer_load = CNT_W'(RST_CYCLES - 1);
      ST_SETTLE:    timer_load = CNT_W'(SETTLE_CYCLES - 1);
      ST_SYNC:      timer_load = CNT_W'(SYNC_CYCLES - 1);
      ST_WAIT_LINK: timer_load = CNT_W'(LINK_TIMEOUT - 1);
      default:      timer_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (state_d != state_q)
        timer_q <= timer_load;
      else if (timer_q != '0)
        timer_q <= timer_q - CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    retry_d    = retry_q;
    lost       = 1'b0;
    rstb_o     = 1'b0;
    hmc_sync_o = 1'b0;
    rxen_o     = '0;
    txen_o     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      ST_RESET: begin
        busy = 1'b1;
        if (timer_q == '0) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy   = 1'b1;
        rstb_o = 1'b1;
        if (timer_q == '0) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        busy       = 1'b1;
        rstb_o     = 1'b1;
        hmc_sync_o = 1'b1;
        if (timer_q == '0) state_d = ST_ENABLE;
      end
      ST_ENABLE: begin
        busy    = 1'b1;
        rstb_o  = 1'b1;
        rxen_o  = RXEN_MASK;
        txen_o  = TXEN_MASK;
        state_d = ST_WAIT_LINK;
      end
      ST_WAIT_LINK: begin
        busy   = 1'b1;
        rstb_o = 1'b1;
        rxen_o = RXEN_MASK;
        txen_o = TXEN_MASK;
        // A link that comes up on the expiry cycle still wins over the retry.
        if (link_s && gate_ok) begin
          state_d = ST_RUN;
        end else if (timer_q == '0) begin
          if (retry_q < RTY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RUN: begin
        done   = 1'b1;
        rstb_o = 1'b1;
        rxen_o = RXEN_MASK;
        txen_o = TXEN_MASK;
        if (!link_s) begin
          lost    = 1'b1;
          retry_d = '0;
          state_d = ST_RESET;
        end
      end
      ST_FAIL: begin
        err = 1'b1;
        if (start) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start or link loss.
    if (abort) begin
      state_d = ST_IDLE;
      retry_d = '0;
      lost    = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_jesd_link_sequencer.sv
// Self-checking bench for jesd_link_sequencer: directed scenarios plus randomized stimulus against a phase/duration model.
// Honours JLS_SYSREF_GATE_EN when the design is built with it.
module tb_jesd_link_sequencer;

  localparam int         RST    = 4;
  localparam int         SETTLE = 8;
  localparam int         SYNC   = 2;
  localparam int         TMO    = 20;
  localparam int         MAXR   = 2;
  localparam int         SMIN   = 4;
  localparam logic [1:0] RXM    = 2'b11;
  localparam logic [1:0] TXM    = 2'b01;

  localparam int P_IDLE = 0, P_RST = 1, P_SETTLE = 2, P_SYNC = 3;
  localparam int P_EN = 4, P_WAIT = 5, P_RUN = 6, P_FAIL = 7;

  logic       clk = 1'b0;
  logic       rst, start, abort, link_up_i, sysref_i;
  logic       rstb_o, hmc_sync_o, busy, done, err, lost;
  logic [1:0] rxen_o, txen_o, retry_cnt_o;
  logic [2:0] state_o;

  jesd_link_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SETTLE), .SYNC_CYCLES(SYNC), .LINK_TIMEOUT(TMO),
    .MAX_RETRIES(MAXR), .RXEN_MASK(RXM), .TXEN_MASK(TXM), .CNT_W(8), .SYSREF_MIN(SMIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .link_up_i(link_up_i), .sysref_i(sysref_i),
    .rstb_o(rstb_o), .hmc_sync_o(hmc_sync_o), .rxen_o(rxen_o), .txen_o(txen_o), .busy(busy),
    .done(done), .err(err), .lost(lost), .state_o(state_o), .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current phase, cycles left in it, retries used, SYSREF edges seen since ENABLE.
  int m_ph, m_rem, m_retry, m_edges;
  bit l_d1, l_d2, s_d1, s_d2, s_d3;
  // Observations of the DUT, summed per scenario.
  int n_rst_low, n_settle_hi, n_sync, n_wait, n_lost, max_retry;
  bit rnd_lk, rnd_sr;
  int rnd_hold;

  function automatic int dur_of(input int p);
    case (p)
      P_RST:    return RST;
      P_SETTLE: return SETTLE;
      P_SYNC:   return SYNC;
      P_EN:     return 1;
      P_WAIT:   return TMO;
      default:  return 0;
    endcase
  endfunction

  task automatic enter(input int p);
    m_ph  = p;
    m_rem = dur_of(p);
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_rem = 0; m_retry = 0; m_edges = 0;
    l_d1 = 0; l_d2 = 0; s_d1 = 0; s_d2 = 0; s_d3 = 0;
  endtask

  task automatic clear_obs();
    n_rst_low = 0; n_settle_hi = 0; n_sync = 0; n_wait = 0; n_lost = 0; max_retry = 0;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic cycle(input bit st, input bit ab, input bit lk, input bit sr);
    bit          ls, gate, e_lost;
    logic [1:0]  e_rx, e_tx;
    logic [11:0] e_pins, g_pins;
    @(negedge clk);
    start = st; abort = ab; link_up_i = lk; sysref_i = sr;
    #1;
    ls = l_d2;
`ifdef JLS_SYSREF_GATE_EN
    gate = (m_edges >= SMIN);
`else
    gate = 1'b1;
`endif
    e_rx   = (m_ph inside {[P_EN:P_RUN]}) ? RXM : 2'b00;
    e_tx   = (m_ph inside {[P_EN:P_RUN]}) ? TXM : 2'b00;
    e_lost = !ab && (m_ph == P_RUN) && !ls;
    e_pins = {(m_ph inside {[P_SETTLE:P_RUN]}), (m_ph == P_SYNC), e_rx, e_tx,
              (m_ph inside {[P_RST:P_WAIT]}), (m_ph == P_RUN), (m_ph == P_FAIL), e_lost, 2'(m_retry)};
    g_pins = {rstb_o, hmc_sync_o, rxen_o, txen_o, busy, done, err, lost, retry_cnt_o};
    check("state", 32'(state_o), 32'(m_ph));
    check("pins", 32'(g_pins), 32'(e_pins));

    if (state_o == 3'd1 && !rstb_o) n_rst_low++;
    if (state_o == 3'd2 && rstb_o)  n_settle_hi++;
    if (hmc_sync_o)                 n_sync++;
    if (state_o == 3'd5)            n_wait++;
    if (lost)                       n_lost++;
    if (int'(retry_cnt_o) > max_retry) max_retry = int'(retry_cnt_o);

    if (m_ph == P_EN) m_edges = 0;
    else if (s_d2 && !s_d3 && m_edges < SMIN) m_edges++;

    if (ab) begin
      m_ph = P_IDLE; m_rem = 0; m_retry = 0;
    end else begin
      case (m_ph)
        P_IDLE, P_FAIL: if (st) begin enter(P_RST); m_retry = 0; end
        P_RST, P_SETTLE, P_SYNC, P_EN: if (m_rem <= 1) enter(m_ph + 1); else m_rem--;
        P_WAIT: begin
          if (ls && gate) enter(P_RUN);
          else if (m_rem <= 1) begin
            if (m_retry < MAXR) begin m_retry++; enter(P_RST); end
            else enter(P_FAIL);
          end else m_rem--;
        end
        P_RUN: if (!ls) begin enter(P_RST); m_retry = 0; end
        default: ;
      endcase
    end
    l_d2 = l_d1; l_d1 = lk;
    s_d3 = s_d2; s_d2 = s_d1; s_d1 = sr;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; link_up_i = 0; sysref_i = 0;
    model_reset();
    clear_obs();
    #1;
    check("rst_state", 32'(state_o), 0);
    check("rst_pins", 32'({rstb_o, hmc_sync_o, rxen_o, txen_o, busy, done, err, lost, retry_cnt_o}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) cycle(0, 0, 0, 0);
    check("idle_quiet", 32'(state_o), 0);

    // Normal bring-up; link_up_i rises 5 cycles after ENABLE.
    clear_obs();
    cycle(1, 0, 0, 0);
    for (int i = 1; i < 20; i++) cycle(0, 0, 0, 1'(i % 2));
    for (int i = 20; i < 50; i++) cycle(0, 0, 1, 1'(i % 2));
    check("norm_run", 32'(state_o), 6);
    check("norm_done", 32'(done), 1);
    check("norm_rxen", 32'(rxen_o), 3);
    check("norm_rst_low", 32'(n_rst_low), 4);
    check("norm_settle", 32'(n_settle_hi), 8);
    check("norm_sync_w", 32'(n_sync), 2);

    // Link drop in RUN, then recovery.
    clear_obs();
    repeat (3) cycle(0, 0, 0, 0);
    check("drop_lost", 32'(n_lost), 1);
    cycle(0, 0, 0, 0);
    check("drop_state", 32'(state_o), 1);
    check("drop_rxen", 32'(rxen_o), 0);
    check("drop_retry", 32'(retry_cnt_o), 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 1, 1'(i % 2));
    check("recover_run", 32'(state_o), 6);

    // Link never comes up: three attempts then FAIL, then restart.
    cycle(0, 1, 0, 0);
    clear_obs();
    cycle(1, 0, 0, 0);
    repeat (110) cycle(0, 0, 0, 0);
    check("fail_state", 32'(state_o), 7);
    check("fail_err", 32'(err), 1);
    check("fail_rstb", 32'(rstb_o), 0);
    check("fail_wait_cyc", 32'(n_wait), 60);
    check("fail_max_retry", 32'(max_retry), 2);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("fail_restart", 32'(state_o), 1);
    check("fail_err_clr", 32'(err), 0);

    // Abort and start together during SYNC.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check("abort_in_sync", 32'(hmc_sync_o), 1);
    cycle(0, 0, 0, 0);
    check("abort_idle", 32'(state_o), 0);
    check("abort_sync_lo", 32'(hmc_sync_o), 0);

    // Asynchronous reset in the middle of the sync pulse.
    cycle(1, 0, 0, 0);
    repeat (13) cycle(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state_o), 0);
    check("arst_sync", 32'(hmc_sync_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(0, 0, 0, 0);

`ifdef JLS_SYSREF_GATE_EN
    // Two SYSREF edges are not enough; the fourth lets the link through.
    cycle(1, 0, 0, 0);
    repeat (15) cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, (i < 4) ? 1'(~i & 1) : 1'b0);
    check("gate_hold", 32'(state_o), 5);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, (i < 4) ? 1'(~i & 1) : 1'b0);
    check("gate_run", 32'(state_o), 6);
    cycle(0, 1, 0, 0);
`endif

    // Randomized traffic: held link levels, rare start/abort, noisy SYSREF.
    rnd_lk = 0; rnd_sr = 0; rnd_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rnd_hold == 0) begin
        rnd_lk   = ~rnd_lk;
        rnd_hold = rnd_lk ? int'($urandom_range(120, 20)) : int'($urandom_range(40, 1));
      end
      rnd_hold--;
      if ($urandom_range(2, 0) == 0) rnd_sr = ~rnd_sr;
      cycle($urandom_range(39, 0) == 0, $urandom_range(399, 0) == 0, rnd_lk, rnd_sr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
